// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - buffers ALU commands in a FIFO and issues them one at a time to an attached combinational alu.
// Optional ALU_ISSUER_STICKY_EN adds a sticky {cout,overflow} output.
module alu_cmd_issuer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_cin,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  input  logic             alu_negative,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic [3:0]       rsp_flags,
  output logic [7:0]       rsp_seq
`ifdef ALU_ISSUER_STICKY_EN
  ,
  output logic [1:0]       sticky
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 5 + 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [3:0]       alu_opcode_q, alu_opcode_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic             alu_cin_q, alu_cin_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;
  logic [7:0]       rsp_seq_q, rsp_seq_d;
  logic [1:0]       sticky_q, sticky_d;
  logic             push, pop;
  logic [EW-1:0]    head;

  // Full is judged on the registered count only, so a pop never frees a slot in the same cycle.
  assign cmd_ready = (count_q < CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    state_d      = state_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_cin_d    = alu_cin_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_y_d      = rsp_y_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_seq_d    = rsp_seq_q;
    sticky_d     = sticky_q;
    pop          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d      = S_DRIVE;
          alu_opcode_d = head[EW-1 -: 4];
          alu_a_d      = head[2*WIDTH : WIDTH+1];
          alu_b_d      = head[WIDTH:1];
          alu_cin_d    = head[0];
        end
      end
      S_DRIVE: begin
        state_d      = S_RESP;
        pop          = 1'b1;
        rsp_valid_d  = 1'b1;
        rsp_y_d      = alu_y;
        rsp_flags_d  = {alu_cout, alu_overflow, alu_negative, alu_zero};
        sticky_d     = sticky_q | {alu_cout, alu_overflow};
        alu_opcode_d = '0;
        alu_a_d      = '0;
        alu_b_d      = '0;
        alu_cin_d    = 1'b0;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_seq_d   = rsp_seq_q + 8'd1;
          if (count_q != '0) begin
            state_d      = S_DRIVE;
            alu_opcode_d = head[EW-1 -: 4];
            alu_a_d      = head[2*WIDTH : WIDTH+1];
            alu_b_d      = head[WIDTH:1];
            alu_cin_d    = head[0];
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = {cmd_opcode, cmd_a, cmd_b, cmd_cin};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cin_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_y_q      <= '0;
      rsp_flags_q  <= '0;
      rsp_seq_q    <= '0;
`ifdef ALU_ISSUER_STICKY_EN
      sticky_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_cin_q    <= alu_cin_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_y_q      <= rsp_y_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_seq_q    <= rsp_seq_d;
`ifdef ALU_ISSUER_STICKY_EN
      sticky_q     <= sticky_d;
`endif
    end
  end

`ifdef ALU_ISSUER_STICKY_EN
  assign sticky = sticky_q;
`else
  assign sticky_q = '0;
`endif

  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_cin    = alu_cin_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_y      = rsp_y_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_seq    = rsp_seq_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - directed scoreboard bench for alu_cmd_issuer with a small behavioural alu attached.
module tb_alu_cmd_issuer;

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_LLS = 4'd4;
  localparam logic [3:0] OP_ARS = 4'd5;

  typedef struct packed {
    logic [3:0] y;
    logic [3:0] f;
    logic [7:0] seq;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_opcode = '0;
  logic [3:0] cmd_a = '0;
  logic [3:0] cmd_b = '0;
  logic       cmd_cin = 1'b0;
  logic [3:0] alu_opcode;
  logic [3:0] alu_a, alu_b;
  logic       alu_cin;
  logic [3:0] alu_y;
  logic       alu_cout, alu_overflow, alu_negative, alu_zero;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_y;
  logic [3:0] rsp_flags;
  logic [7:0] rsp_seq;
`ifdef ALU_ISSUER_STICKY_EN
  logic [1:0] sticky;
`endif

  exp_t       sb[$];
  logic [7:0] exp_seq = 8'd0;
  logic       ready_hold = 1'b0;
  int         errors = 0;
  int         checks = 0;
  logic [3:0] vals [4];

  always #5 clk = ~clk;

  alu_cmd_issuer #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_cout(alu_cout), .alu_overflow(alu_overflow),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_flags(rsp_flags), .rsp_seq(rsp_seq)
`ifdef ALU_ISSUER_STICKY_EN
    , .sticky(sticky)
`endif
  );

  // Behavioural stand-in for the attached combinational alu.
  always_comb begin
    alu_y        = '0;
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    case (alu_opcode)
      OP_ADD: begin
        {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
        alu_overflow = (alu_a[3] == alu_b[3]) && (alu_y[3] != alu_a[3]);
      end
      OP_AND: alu_y = alu_a & alu_b;
      OP_XOR: alu_y = alu_a ^ alu_b;
      OP_LLS: alu_y = alu_a << alu_b;
      OP_ARS: alu_y = $unsigned($signed(alu_a) >>> alu_b);
      default: alu_y = '0;
    endcase
  end
  assign alu_negative = alu_y[3];
  assign alu_zero     = (alu_y == 4'd0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic cin, input logic [3:0] ey, input logic [3:0] ef);
    int n = 0;
    @(negedge clk);
    cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("push_accept", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    sb.push_back('{y: ey, f: ef, seq: exp_seq});
    exp_seq = exp_seq + 8'd1;
    #1 cmd_valid = 1'b0;
  endtask

  task automatic collect();
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
    chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rsp_y", {28'd0, rsp_y}, {28'd0, e.y});
      chk("rsp_flags", {28'd0, rsp_flags}, {28'd0, e.f});
      chk("rsp_seq", {24'd0, rsp_seq}, {24'd0, e.seq});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = ready_hold;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_y", {28'd0, rsp_y}, 32'd0);
    chk("rst_rsp_flags", {28'd0, rsp_flags}, 32'd0);
    chk("rst_rsp_seq", {24'd0, rsp_seq}, 32'd0);
    chk("rst_alu", {23'd0, alu_opcode, alu_a, alu_b, alu_cin}, 32'd0);
    rst_n = 1'b1;

    // Latency: accept at N, DRIVE at N+1, response from N+2
    push_cmd(OP_LLS, 4'b0001, 4'b0001, 1'b0, 4'b0010, 4'b0000);
    chk("lat_n_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_n1_valid", {31'd0, rsp_valid}, 32'd0);
    chk("drive_opcode", {28'd0, alu_opcode}, {28'd0, OP_LLS});
    chk("drive_a", {28'd0, alu_a}, 32'd1);
    @(posedge clk); #1;
    chk("lat_n2_valid", {31'd0, rsp_valid}, 32'd1);
    chk("resp_alu_zero", {23'd0, alu_opcode, alu_a, alu_b, alu_cin}, 32'd0);
    collect();

    // Two commands, rsp_ready held high
    ready_hold = 1'b1; rsp_ready = 1'b1;
    push_cmd(OP_ARS, 4'b1001, 4'b0001, 1'b0, 4'b1100, 4'b0010);
    push_cmd(OP_XOR, 4'b1100, 4'b1010, 1'b0, 4'b0110, 4'b0000);
    collect();
    collect();

    // Backpressure: one response parked, four more fill the FIFO, fifth held off
    ready_hold = 1'b0; rsp_ready = 1'b0;
    push_cmd(OP_XOR, 4'd1, 4'd0, 1'b0, 4'd1, 4'b0000);
    for (int n = 0; n < 50 && !rsp_valid; n++) @(negedge clk);
    chk("bp_parked", {31'd0, rsp_valid}, 32'd1);
    vals[0] = 4'd2; vals[1] = 4'd9; vals[2] = 4'd5; vals[3] = 4'd12;
    for (int i = 0; i < 4; i++) begin
      push_cmd(OP_XOR, vals[i], 4'd0, 1'b0, vals[i], {2'b00, vals[i][3], 1'b0});
      chk("bp_cmd_ready", {31'd0, cmd_ready}, (i == 3) ? 32'd0 : 32'd1);
    end
    @(negedge clk);
    cmd_opcode = OP_XOR; cmd_a = 4'd7; cmd_b = 4'd0; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_held_off", {31'd0, cmd_ready}, 32'd0);
    end
    cmd_valid = 1'b0;
    collect();
    push_cmd(OP_XOR, 4'd7, 4'd0, 1'b0, 4'd7, 4'b0000);
    for (int i = 0; i < 5; i++) collect();

    // 256 AND ops, sequence number wraps 255 -> 0
    ready_hold = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      push_cmd(OP_AND, 4'b1111, 4'b0111, 1'b0, 4'b0111, 4'b0000);
      collect();
    end
    chk("wrap_seq_next", {24'd0, exp_seq}, 32'd9);

    // Reset while parked in RESP with two buffered
    ready_hold = 1'b0; rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_cmd(OP_AND, 4'd3, 4'd1, 1'b0, 4'd1, 4'b0000);
    for (int n = 0; n < 50 && !rsp_valid; n++) @(negedge clk);
    chk("mid_parked", {31'd0, rsp_valid}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("mid_rst_seq", {24'd0, rsp_seq}, 32'd0);
    chk("mid_rst_alu", {23'd0, alu_opcode, alu_a, alu_b, alu_cin}, 32'd0);
    sb.delete();
    exp_seq = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1; ready_hold = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", {31'd0, rsp_valid}, 32'd0);
    end
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    push_cmd(OP_ADD, 4'd2, 4'd3, 1'b1, 4'd6, 4'b0000);
    collect();

`ifdef ALU_ISSUER_STICKY_EN
    push_cmd(OP_ADD, 4'b0111, 4'b0001, 1'b0, 4'b1000, 4'b0110);
    collect();
    chk("sticky_set", {30'd0, sticky}, 32'd1);
    push_cmd(OP_AND, 4'b1111, 4'b0111, 1'b0, 4'b0111, 4'b0000);
    collect();
    chk("sticky_hold", {30'd0, sticky}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("sticky_rst", {30'd0, sticky}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width; must match the attached alu.
REQ-002 SHALL have parameter DEPTH, default 4, command FIFO entries; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command slot free.
REQ-007 SHALL have port cmd_opcode  input  4  opcode, encoding per shared ops.svh.
REQ-008 SHALL have port cmd_a, cmd_b  input  WIDTH  operands.
REQ-009 SHALL have port cmd_cin  input  1  carry-in.
REQ-010 SHALL have port alu_opcode  output  4; alu_a, alu_b  output  WIDTH; alu_cin  output  1  drive to alu.
REQ-011 SHALL have port alu_y  input  WIDTH; alu_cout, alu_overflow, alu_negative, alu_zero  input  1 each  alu results.
REQ-012 SHALL have port rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-013 SHALL have port rsp_y  output  WIDTH; rsp_flags  output  4  {cout,overflow,negative,zero}.
REQ-014 SHALL have port rsp_seq  output  8  response sequence number.

Function
REQ-015 SHALL accept a command on rising edge with cmd_valid && cmd_ready, pushing {opcode,a,b,cin} into the FIFO.
REQ-016 SHALL drive cmd_ready = (count < DEPTH), from registered count only; no same-cycle pop bypass when full.
REQ-017 SHALL implement FSM IDLE, DRIVE, RESP; IDLE->DRIVE when FIFO non-empty.
REQ-018 SHALL, in DRIVE, drive FIFO head onto alu_* ports for exactly one cycle; alu treated as purely combinational.
REQ-019 SHALL, on the edge leaving DRIVE, register alu_y and the four flags into rsp_y/rsp_flags, pop the FIFO, enter RESP.
REQ-020 SHALL drive alu_* ports to zero in IDLE and RESP.
REQ-021 SHALL hold rsp_valid=1 and rsp_y/rsp_flags/rsp_seq stable in RESP until rsp_ready; rsp_valid=0 otherwise.
REQ-022 SHALL, on rsp handshake, increment rsp_seq modulo 256 (255->0) and go DRIVE if FIFO non-empty else IDLE.
REQ-023 SHALL give latency: command accepted at edge N into empty IDLE block -> rsp_valid high from edge N+2.
REQ-024 SHALL allow a push in the same cycle as a pop; count unchanged.
REQ-025 SHALL preserve command order; rsp_seq of k-th response (from reset) = (k-1) mod 256.

Reset
REQ-026 SHALL, on rst_n low, asynchronously: FSM IDLE, FIFO empty, count 0, cmd_ready 1, rsp_valid 0, rsp_y 0, rsp_flags 0, rsp_seq 0, alu_* 0.
REQ-027 SHALL discard any in-flight or buffered commands when reset asserts mid-operation; no response emitted for them.
REQ-028 SHALL leave reset deassertion unqualified; first command accepted on the first edge with rst_n high.

Configuration
REQ-029 SHALL, with ALU_ISSUER_STICKY_EN defined, add output sticky  output  2  {cout,overflow}, OR-accumulated at each capture, cleared by reset only.
REQ-030 SHALL, without ALU_ISSUER_STICKY_EN, have no sticky port and no accumulation logic.

Verification
REQ-031 SHALL test: reset, push LL_SHIFT_OP a=0001 b=0001 cin=0, alu attached -> rsp_valid at edge N+2, rsp_y=0010, rsp_seq=0.
REQ-032 SHALL test: push AR_SHIFT_OP a=1001 b=0001 then XOR_OP a=1100 b=1010, rsp_ready=1 -> rsp_y 1100 then 0110, rsp_seq 0 then 1.
REQ-033 SHALL test: rsp_ready=0, push 5 commands with DEPTH=4 -> cmd_ready drops after 4th accept, 5th held off; release -> all in order.
REQ-034 SHALL test: 256 back-to-back AND_OP a=1111 b=0111 -> all rsp_y=0111, rsp_seq wraps 255->0.
REQ-035 SHALL test: rst_n low while in RESP with 2 buffered -> rsp_valid 0 immediately, no further responses, cmd_ready 1.
REQ-036 SHALL test: with ALU_ISSUER_STICKY_EN, an op producing overflow=1 then one with 0 -> sticky[0]=1 persists until reset.
